fp8_log_mant_arbiter: RTL and testbench
=======================================

Name: fp8_log_mant_arbiter

Overview:
- Shares one combinational E4M3 mantissa-log lookup unit among NUM_REQ requesters.
- Each requester offers an 8-bit E4M3 operand over a valid/ready handshake.
- Each cycle the block grants at most one requester, using round-robin order.
- For the granted operand, the block drives the shared lookup's 4-bit mantissa input, captures the 8-bit log result together with the sign, exponent, class flags and requester ID, and presents that record on one registered response port with backpressure.
- Sits between the per-lane operand sources and the downstream exponent-combine stage of the fp8 log datapath.

Parameters:
NUM_REQ  4  number of requesters (2..16)
ID_W  $clog2(NUM_REQ)  width of the requester ID field

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit set
req_data  in  NUM_REQ*8  E4M3 operands; requester i occupies [8i+7:8i], packed as {S,E[3:0],M[2:0]}
lut_mant  out  4  to shared lookup: {E!=0, M[2:0]} of the granted operand
lut_log  in  8  from shared lookup: log2(mantissa) in E4M3, combinational from lut_mant
resp_valid  out  1  response register holds a result
resp_ready  in  1  downstream accept
resp_id  out  ID_W  index of the requester that produced the response
resp_log_mant  out  8  captured lut_log
resp_exp  out  4  E field of the operand
resp_sign  out  1  S bit of the operand
resp_sub  out  1  E==0 and M!=0 (subnormal)
resp_zero  out  1  E==0 and M==0
resp_nan  out  1  E==4'hF and M==3'h7

Behaviour:
- Reset (rst=1 at a clock edge):
  - resp_valid=0 and every resp_* field =0.
  - Round-robin pointer =0.
  - req_ready is all-zero during any cycle where rst=1.
- Reset mid-transfer drops the held response. A request handshaked in the reset cycle is not captured.
- Slot free: can_accept = !resp_valid | resp_ready.
- Grant selection (combinational):
  - Search for the first requester with req_valid set, starting at the pointer and wrapping modulo NUM_REQ.
  - Grant it only if can_accept. Otherwise no grant.
  - req_ready[g]=1 only for the granted index g.
- Handshake:
  - Transfer on requester i when req_valid[i] & req_ready[i].
  - req_ready must not depend on req_data.
  - A requester holding valid keeps its data stable until accepted.
- lut_mant: driven from the granted operand in the grant cycle. When there is no grant it is driven from requester[pointer]'s operand; this value is don't-care and only needs to be deterministic.
- Capture:
  - On a transfer, the next edge loads resp_log_mant=lut_log, resp_id=g, and the exp, sign and flag fields decoded from the operand.
  - resp_valid goes to 1 on that edge.
  - Latency is 1 cycle from handshake to resp_valid.
- Throughput: with resp_ready held at 1, one transfer per cycle (back-to-back).
- Drain: resp_valid & resp_ready with no new transfer causes resp_valid to go to 0 at the next edge. The resp_* fields may hold their stale values.
- Stall: resp_valid & !resp_ready means no grant and every resp_* field holds its value.
- Pointer update: on a transfer, pointer becomes (g+1) mod NUM_REQ. Otherwise it holds.
- Fairness: a continuously valid requester is granted within NUM_REQ accepted transfers.
- The block does not alter special values.
  - Zero operand: lut_mant=4'b0000, and whatever lut_log returns (0x3F) is passed through with resp_zero=1.
  - NaN operand: the result passes through with resp_nan=1.
- Simultaneous drain and grant in the same cycle: the new result replaces the old one and resp_valid stays 1.

Test Plan:
- Single request, lane 0, data 0x3C (E=7, M=100), resp_ready=1 -> lut_mant=4'b1100; next cycle resp_valid=1, resp_log_mant=0x31, resp_exp=7, resp_id=0, all flags 0.
- Subnormal and zero: lane 2 sends 0x03, then 0x00 -> lut_mant 4'b0011 then 4'b0000; responses 0x31 with resp_sub=1, then 0x3F with resp_zero=1, both with resp_id=2.
- All 4 lanes continuously valid, resp_ready=1 -> grant order 0,1,2,3,0,1,... with one response per cycle and no bubbles.
- Backpressure: resp_ready=0 with a response held -> req_ready=0 and the response fields are stable for 5 cycles. Raise resp_ready -> the next grant follows in the same cycle, with no loss or duplication.
- NaN: lane 1 sends 0x7F -> resp_nan=1, resp_sign=0, resp_exp=4'hF.
- Assert rst while resp_valid=1 and lane 3 is valid -> after the edge resp_valid=0, pointer=0, and lane 3's pending operand is not consumed; the first grant after reset goes to lane 0 if lane 0 is valid.

Source files
------------

// File: rtl/fp8_log_mant_arbiter.sv
// rtl/fp8_log_mant_arbiter.sv - round-robin arbiter sharing one E4M3 mantissa-log lookup
// Grants one operand per cycle to the shared lookup and registers the decoded result record.
module fp8_log_mant_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [3:0]           lut_mant,
   input  logic [7:0]           lut_log,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ID_W-1:0]      resp_id,
   output logic [7:0]           resp_log_mant,
   output logic [3:0]           resp_exp,
   output logic                 resp_sign,
   output logic                 resp_sub,
   output logic                 resp_zero,
   output logic                 resp_nan
);

   logic [7:0]      ops [NUM_REQ];
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] gidx;
   logic [ID_W-1:0] sel;
   logic [ID_W-1:0] cand;
   logic [ID_W:0]   sum;
   logic            found;
   logic            can_accept;
   logic            grant;
   logic [7:0]      sel_op;
   logic [3:0]      sel_e;
   logic [2:0]      sel_m;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
      assign ops[i] = req_data[8*i +: 8];
   end

   assign can_accept = !resp_valid || resp_ready;

   // Search modulo NUM_REQ from the pointer; the sum stays below 2*NUM_REQ.
   always_comb begin
      found = 1'b0;
      gidx  = ptr;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_REQ))
            sum = sum - (ID_W+1)'(NUM_REQ);
         cand = sum[ID_W-1:0];
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            gidx  = cand;
         end
      end
   end

   assign grant = found && can_accept && !rst;

   always_comb begin
      req_ready = '0;
      if (grant)
         req_ready[gidx] = 1'b1;
   end

   assign sel      = grant ? gidx : ptr;
   assign sel_op   = ops[sel];
   assign sel_e    = sel_op[6:3];
   assign sel_m    = sel_op[2:0];
   assign lut_mant = {(sel_e != 4'h0), sel_m};

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr           <= '0;
         resp_valid    <= 1'b0;
         resp_id       <= '0;
         resp_log_mant <= '0;
         resp_exp      <= '0;
         resp_sign     <= 1'b0;
         resp_sub      <= 1'b0;
         resp_zero     <= 1'b0;
         resp_nan      <= 1'b0;
      end else if (grant) begin
         ptr           <= (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + ID_W'(1);
         resp_valid    <= 1'b1;
         resp_id       <= gidx;
         resp_log_mant <= lut_log;
         resp_exp      <= sel_e;
         resp_sign     <= sel_op[7];
         resp_sub      <= (sel_e == 4'h0) && (sel_m != 3'h0);
         resp_zero     <= (sel_e == 4'h0) && (sel_m == 3'h0);
         resp_nan      <= (sel_e == 4'hF) && (sel_m == 3'h7);
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp8_log_mant_arbiter.sv
// tb/tb_fp8_log_mant_arbiter.sv - randomized model-checked bench for fp8_log_mant_arbiter
// Drives lanes that hold data until accepted and checks every cycle against a round-robin model.
module tb_fp8_log_mant_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*8-1:0] req_data;
   logic [3:0]     lut_mant;
   logic [7:0]     lut_log;
   logic           resp_valid;
   logic           resp_ready;
   logic [IW-1:0]  resp_id;
   logic [7:0]     resp_log_mant;
   logic [3:0]     resp_exp;
   logic           resp_sign;
   logic           resp_sub;
   logic           resp_zero;
   logic           resp_nan;

   always #5 clk = ~clk;

   fp8_log_mant_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .lut_mant(lut_mant), .lut_log(lut_log),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_log_mant(resp_log_mant), .resp_exp(resp_exp), .resp_sign(resp_sign),
      .resp_sub(resp_sub), .resp_zero(resp_zero), .resp_nan(resp_nan)
   );

   // Stand-in for the shared lookup: fixed table indexed by {E!=0, M}.
   function automatic logic [7:0] lut_f(input logic [3:0] m);
      case (m)
         4'h0:    lut_f = 8'h3F;
         4'h3:    lut_f = 8'h31;
         4'hC:    lut_f = 8'h31;
         default: lut_f = 8'h40 + {4'h0, m} * 8'd5;
      endcase
   endfunction

   assign lut_log = lut_f(lut_mant);

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus state
   bit         lv [N];
   logic [7:0] ld [N];
   bit         rr;
   bit         rb;
   int         mode;   // 0: clear on accept, 1: refill on accept, 2: random

   // Model state
   int         m_ptr;
   bit         m_val;
   bit         m_known;
   int         m_id;
   logic [7:0] m_log;
   logic [3:0] m_exp;
   bit         m_sign, m_sub, m_zero, m_nan;

   task automatic drive_inputs();
      rst        = rb;
      resp_ready = rr;
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = lv[i];
         req_data[8*i +: 8] = ld[i];
      end
   endtask

   function automatic int model_grant();
      if (rb || (m_val && !rr)) return -1;
      for (int k = 0; k < N; k++)
         if (lv[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic step();
      int         g;
      logic [N-1:0] er;
      logic [3:0] e;
      logic [2:0] mm;
      drive_inputs();
      #1;
      g  = model_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      if (g >= 0)
         chk("lut_mant", 32'(lut_mant), 32'({(ld[g][6:3] != 4'h0), ld[g][2:0]}));
      chk("resp_valid", 32'(resp_valid), 32'(m_val));
      if (m_val || m_known) begin
         chk("resp_id",   32'(resp_id),       32'(m_id));
         chk("resp_log",  32'(resp_log_mant), 32'(m_log));
         chk("resp_exp",  32'(resp_exp),      32'(m_exp));
         chk("resp_flags", 32'({resp_sign, resp_sub, resp_zero, resp_nan}),
             32'({m_sign, m_sub, m_zero, m_nan}));
      end
      @(posedge clk);
      if (rb) begin
         m_ptr = 0; m_val = 0; m_known = 1;
         m_id = 0; m_log = 0; m_exp = 0;
         m_sign = 0; m_sub = 0; m_zero = 0; m_nan = 0;
      end else if (g >= 0) begin
         e  = ld[g][6:3];
         mm = ld[g][2:0];
         m_val  = 1; m_known = 0;
         m_id   = g;
         m_log  = lut_f({(e != 4'h0), mm});
         m_exp  = e;
         m_sign = ld[g][7];
         m_sub  = (e == 0) && (mm != 0);
         m_zero = (e == 0) && (mm == 0);
         m_nan  = (e == 4'hF) && (mm == 3'h7);
         m_ptr  = (g + 1) % N;
         if (mode == 0 || (mode == 2 && $urandom_range(0, 1) == 0)) lv[g] = 0;
         else ld[g] = 8'($urandom_range(0, 255));
      end else if (rr) begin
         m_val = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      rb = 1;
      step();
      step();
      rb = 0;
   endtask

   initial begin
      logic [7:0] held_log;
      logic [IW-1:0] held_id;
      for (int i = 0; i < N; i++) begin lv[i] = 0; ld[i] = 8'h00; end
      rr = 1; rb = 1; mode = 0;
      m_ptr = 0; m_val = 0; m_known = 0;
      m_id = 0; m_log = 0; m_exp = 0; m_sign = 0; m_sub = 0; m_zero = 0; m_nan = 0;
      drive_inputs();
      @(posedge clk); #1;
      do_reset();
      chk("rst_valid", 32'(resp_valid), 32'h0);
      chk("rst_fields", 32'({resp_id, resp_log_mant, resp_exp, resp_sign, resp_sub, resp_zero, resp_nan}), 32'h0);

      // Lane 0, 0x3C
      lv[0] = 1; ld[0] = 8'h3C;
      drive_inputs(); #1;
      chk("t1_lut_mant", 32'(lut_mant), 32'hC);
      step();
      chk("t1_valid", 32'(resp_valid), 32'h1);
      chk("t1_log", 32'(resp_log_mant), 32'h31);
      chk("t1_exp", 32'(resp_exp), 32'h7);
      chk("t1_id", 32'(resp_id), 32'h0);
      chk("t1_flags", 32'({resp_sign, resp_sub, resp_zero, resp_nan}), 32'h0);

      // Lane 2 subnormal then zero
      lv[2] = 1; ld[2] = 8'h03;
      drive_inputs(); #1;
      chk("t2_lut_sub", 32'(lut_mant), 32'h3);
      step();
      chk("t2_sub_log", 32'(resp_log_mant), 32'h31);
      chk("t2_sub_flag", 32'(resp_sub), 32'h1);
      chk("t2_sub_id", 32'(resp_id), 32'h2);
      lv[2] = 1; ld[2] = 8'h00;
      drive_inputs(); #1;
      chk("t2_lut_zero", 32'(lut_mant), 32'h0);
      step();
      chk("t2_zero_log", 32'(resp_log_mant), 32'h3F);
      chk("t2_zero_flag", 32'(resp_zero), 32'h1);
      chk("t2_zero_id", 32'(resp_id), 32'h2);
      step();

      // All lanes continuously valid
      do_reset();
      mode = 1; rr = 1;
      for (int i = 0; i < N; i++) begin lv[i] = 1; ld[i] = 8'($urandom_range(0, 255)); end
      for (int k = 0; k < 8; k++) begin
         step();
         chk("rr_order", 32'(resp_id), 32'(k % N));
         chk("rr_nobubble", 32'(resp_valid), 32'h1);
      end

      // Backpressure
      held_log = resp_log_mant;
      held_id  = resp_id;
      rr = 0;
      for (int k = 0; k < 5; k++) step();
      chk("bp_log_stable", 32'(resp_log_mant), 32'(held_log));
      chk("bp_id_stable", 32'(resp_id), 32'(held_id));
      rr = 1;
      drive_inputs(); #1;
      chk("bp_release_ready", 32'(req_ready), 32'h1);
      step();
      chk("bp_release_id", 32'(resp_id), 32'h0);

      // NaN on lane 1
      mode = 0;
      for (int i = 0; i < N; i++) lv[i] = 0;
      step();
      do_reset();
      lv[1] = 1; ld[1] = 8'h7F;
      step();
      chk("nan_flag", 32'(resp_nan), 32'h1);
      chk("nan_sign", 32'(resp_sign), 32'h0);
      chk("nan_exp", 32'(resp_exp), 32'hF);

      // Reset mid-transfer
      for (int i = 0; i < N; i++) begin lv[i] = 1; ld[i] = 8'($urandom_range(0, 255)); end
      step();
      rr = 0; rb = 1;
      step();
      chk("mid_rst_valid", 32'(resp_valid), 32'h0);
      rb = 0; rr = 1; lv[0] = 1;
      step();
      chk("mid_rst_first", 32'(resp_id), 32'h0);
      for (int k = 0; k < 4; k++) step();

      // Randomized phase
      mode = 2;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if (!lv[i] && $urandom_range(0, 1) == 1) begin
               lv[i] = 1; ld[i] = 8'($urandom_range(0, 255));
            end
         rr = ($urandom_range(0, 3) != 0);
         rb = ($urandom_range(0, 199) == 0);
         step();
      end
      rb = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
